// File: rtl/uart_core_if.sv
// Host-side FIFO port bundle of the UART core: RX FIFO read side and TX FIFO write side.
`timescale 1ns/1ps
interface uart_core_if;
    logic       rd_uart_en;
    logic       Enable_rx;
    logic [7:0] RX_data;
    logic       Empty;
    logic [7:0] TX_data;
    logic       wr_uart_en;
    logic       Full;

    modport master (
        output rd_uart_en, Enable_rx, TX_data, wr_uart_en,
        input  RX_data, Empty, Full
    );

    modport slave (
        input  rd_uart_en, Enable_rx, TX_data, wr_uart_en,
        output RX_data, Empty, Full
    );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with one first-word-fall-through byte FIFO per direction.
// Bit timing comes from an integer divide of the system clock by the baud rate.
`timescale 1ns/1ps
module uart_core #(
    parameter int C_BAUDRATE    = 115_200,
    parameter int C_SYSTEM_FREQ = 50_000_000,
    parameter int C_FIFO_DEPTH  = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RX,
    output logic       TX,
    uart_core_if.slave host
);
    localparam int BIT_CYC = C_SYSTEM_FREQ / C_BAUDRATE;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int AW      = $clog2(C_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // ---------------- RX synchronizer and FSM ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    state_t          rx_state_reg, rx_state_next;
    logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
    logic [2:0]      rx_bit_reg, rx_bit_next;
    logic [7:0]      rx_shift_reg, rx_shift_next;
    logic            rx_push;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        case (rx_state_reg)
            ST_IDLE: begin
                if (host.Enable_rx && !rx_sync) begin
                    rx_state_next = ST_START;
                    rx_cnt_next   = '0;
                end
            end
            ST_START: begin
                // A start bit that is gone by mid-bit is treated as line noise.
                if (rx_cnt_reg == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_sync, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) rx_state_next = ST_STOP;
                    else                    rx_bit_next   = rx_bit_reg + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets an immediately following start bit be caught.
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_push       = rx_sync;
                    rx_state_next = ST_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg + CW'(1);
                end
            end
            default: rx_state_next = ST_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [C_FIFO_DEPTH];
    logic [AW:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic        rx_empty, rx_full, rx_pop, rx_wr_en;

    assign rx_empty = (rx_wr_ptr_reg == rx_rd_ptr_reg);
    assign rx_full  = (rx_wr_ptr_reg[AW] != rx_rd_ptr_reg[AW]) &&
                      (rx_wr_ptr_reg[AW-1:0] == rx_rd_ptr_reg[AW-1:0]);
    assign rx_pop   = host.rd_uart_en && !rx_empty;
    assign rx_wr_en = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge Clk) begin
        if (rx_wr_en) rx_mem[rx_wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
        end else begin
            if (rx_wr_en) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)   rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
        end
    end

    assign host.RX_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg[AW-1:0]];
    assign host.Empty   = rx_empty;

    // ---------------- TX FIFO ----------------
    logic [7:0]  tx_mem [C_FIFO_DEPTH];
    logic [AW:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic        tx_empty, tx_full, tx_pop, tx_wr_en;

    assign tx_empty = (tx_wr_ptr_reg == tx_rd_ptr_reg);
    assign tx_full  = (tx_wr_ptr_reg[AW] != tx_rd_ptr_reg[AW]) &&
                      (tx_wr_ptr_reg[AW-1:0] == tx_rd_ptr_reg[AW-1:0]);
    assign tx_wr_en = host.wr_uart_en && !tx_full;

    always_ff @(posedge Clk) begin
        if (tx_wr_en) tx_mem[tx_wr_ptr_reg[AW-1:0]] <= host.TX_data;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (tx_wr_en) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)   tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
        end
    end

    assign host.Full = tx_full;

    // ---------------- TX FSM ----------------
    state_t        tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]    tx_bit_reg, tx_bit_next;
    logic [7:0]    tx_shift_reg, tx_shift_next;
    logic          tx_line;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_pop        = 1'b0;
        tx_line       = 1'b1;
        case (tx_state_reg)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop        = 1'b1;
                    tx_shift_next = tx_mem[tx_rd_ptr_reg[AW-1:0]];
                    tx_cnt_next   = '0;
                    tx_state_next = ST_START;
                end
            end
            ST_START: begin
                tx_line = 1'b0;
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = ST_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            ST_DATA: begin
                tx_line = tx_shift_reg[0];
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    if (tx_bit_reg == 3'd7) tx_state_next = ST_STOP;
                    else                    tx_bit_next   = tx_bit_reg + 3'd1;
                end else begin
                    tx_cnt_next = tx_cnt_reg + CW'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_reg == BIT_LAST) tx_state_next = ST_IDLE;
                else                        tx_cnt_next   = tx_cnt_reg + CW'(1);
            end
            default: tx_state_next = ST_IDLE;
        endcase
    end

    // Decoded from state so an asynchronous reset releases the line at once.
    assign TX = tx_line;
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: serial frames are generated/decoded by bit timing
// and compared against byte queues built from the frame rules.
`timescale 1ns/1ps
module tb_uart_core;
    localparam int BAUD  = 115_200;
    localparam int FREQ  = 921_600;
    localparam int DEPTH = 16;
    localparam int BIT   = FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic tx_line;
    int   checks = 0;
    int   errors = 0;

    uart_core_if bus ();

    uart_core #(
        .C_BAUDRATE   (BAUD),
        .C_SYSTEM_FREQ(FREQ),
        .C_FIFO_DEPTH (DEPTH)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .RX   (rx_line),
        .TX   (tx_line),
        .host (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic b;
        for (int i = 0; i < 10; i++) begin
            b = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : data[i-1];
            rx_line = b;
            repeat (BIT) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic pop_one();
        bus.rd_uart_en = 1'b1;
        @(negedge clk);
        bus.rd_uart_en = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        bus.TX_data    = b;
        bus.wr_uart_en = 1'b1;
        @(negedge clk);
        bus.wr_uart_en = 1'b0;
    endtask

    // bits[0] = start sample, bits[8:1] = data, bits[9] = stop sample
    task automatic recv_tx(output logic [9:0] bits, output bit found);
        int n;
        n = 0;
        bits = '0;
        found = 1'b0;
        while (tx_line !== 1'b0 && n < 20 * BIT) begin
            @(negedge clk);
            n++;
        end
        if (tx_line === 1'b0) begin
            found = 1'b1;
            repeat (BIT / 2) @(negedge clk);
            bits[0] = tx_line;
            for (int i = 1; i < 10; i++) begin
                repeat (BIT) @(negedge clk);
                bits[i] = tx_line;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1000);
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx_line); end
        checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", bus.Empty); end
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", bus.Full); end
        checks++; if (bus.RX_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h expected 00", bus.RX_data); end
        $display("reset: idle state observed");
    endtask

    task automatic test_single_rx();
        bus.Enable_rx = 1'b1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_cycles(9 * BIT);
                checks++;
                if (bus.Empty !== 1'b1) begin errors++; $display("FAIL rx_early_empty got %b expected 1", bus.Empty); end
            end
        join
        wait_cycles(4);
        checks++; if (bus.Empty !== 1'b0) begin errors++; $display("FAIL rx_a5_empty got %b expected 0", bus.Empty); end
        checks++; if (bus.RX_data !== 8'hA5) begin errors++; $display("FAIL rx_a5_data got %h expected a5", bus.RX_data); end
        pop_one();
        checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL rx_a5_pop_empty got %b expected 1", bus.Empty); end
        checks++; if (bus.RX_data !== 8'h00) begin errors++; $display("FAIL rx_a5_pop_data got %h expected 00", bus.RX_data); end
        $display("rx byte a5 received");
    endtask

    task automatic test_random_rx();
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            wait_cycles($urandom_range(0, 3 * BIT));
            b = 8'($urandom);
            send_frame(b, 1'b1);
            wait_cycles(2);
            checks++; if (bus.Empty !== 1'b0) begin errors++; $display("FAIL rand_rx_empty[%0d] got %b expected 0", k, bus.Empty); end
            checks++; if (bus.RX_data !== b) begin errors++; $display("FAIL rand_rx_data[%0d] got %h expected %h", k, bus.RX_data, b); end
            pop_one();
            checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL rand_rx_pop[%0d] got %b expected 1", k, bus.Empty); end
            $display("rx random byte %h", b);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        fork
            for (int i = 0; i < 512; i++) send_frame(8'(i), 1'b1);
            begin
                while (got < 512 && cyc < 512 * 10 * BIT + 20 * BIT) begin
                    if (bus.Empty === 1'b0) begin
                        checks++;
                        if (bus.RX_data !== 8'(got)) begin
                            errors++;
                            $display("FAIL b2b_data[%0d] got %h expected %h", got, bus.RX_data, 8'(got));
                        end
                        $display("rx b2b byte %0d = %h", got, bus.RX_data);
                        pop_one();
                        got++;
                    end else begin
                        @(negedge clk);
                    end
                    cyc++;
                end
            end
        join
        checks++; if (got != 512) begin errors++; $display("FAIL b2b_count got %0d expected 512", got); end
    endtask

    task automatic test_overrun();
        logic [7:0] sent[$];
        logic [7:0] b;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom);
            sent.push_back(b);
            send_frame(b, 1'b1);
        end
        wait_cycles(4);
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (bus.RX_data !== sent[k] || bus.Empty !== 1'b0) begin
                errors++;
                $display("FAIL overrun_data[%0d] got %h empty %b expected %h empty 0", k, bus.RX_data, bus.Empty, sent[k]);
            end
            $display("rx kept byte %0d = %h", k, bus.RX_data);
            pop_one();
        end
        checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL overrun_dropped got empty %b expected 1", bus.Empty); end
        send_frame(8'($urandom), 1'b0);
        wait_cycles(3 * BIT);
        checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL framing_err got empty %b expected 1", bus.Empty); end
        bus.Enable_rx = 1'b0;
        send_frame(8'($urandom), 1'b1);
        wait_cycles(3 * BIT);
        checks++; if (bus.Empty !== 1'b1) begin errors++; $display("FAIL rx_disabled got empty %b expected 1", bus.Empty); end
        bus.Enable_rx = 1'b1;
        $display("rx overrun, framing error and disable handled");
    endtask

    task automatic test_tx();
        logic [9:0] bits;
        bit         found;
        int         exp_seq[10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        logic [7:0] vals[17];
        logic [7:0] extra;
        push_tx(8'h3C);
        recv_tx(bits, found);
        checks++; if (!found) begin errors++; $display("FAIL tx_3c_start got none expected frame"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bits[i] !== 1'(exp_seq[i])) begin errors++; $display("FAIL tx_3c_bit[%0d] got %b expected %0d", i, bits[i], exp_seq[i]); end
        end
        $display("tx byte 3c serialized as %b", bits);
        wait_cycles(2 * BIT);
        for (int k = 0; k < 17; k++) vals[k] = 8'($urandom);
        extra = 8'($urandom);
        fork
            begin
                push_tx(vals[0]);
                wait_cycles(3);
                for (int k = 1; k < 17; k++) begin
                    if (k == 16) begin
                        checks++;
                        if (bus.Full !== 1'b0) begin errors++; $display("FAIL tx_full_at15 got %b expected 0", bus.Full); end
                    end
                    push_tx(vals[k]);
                end
                checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL tx_full_at16 got %b expected 1", bus.Full); end
                push_tx(extra);
                checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL tx_full_after17 got %b expected 1", bus.Full); end
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    recv_tx(bits, found);
                    checks++;
                    if (!found || bits[8:1] !== vals[k] || bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_frame[%0d] got found %b frame %b expected data %h", k, found, bits, vals[k]);
                    end
                    $display("tx frame %0d byte %h", k, bits[8:1]);
                end
            end
        join
        recv_tx(bits, found);
        checks++; if (found) begin errors++; $display("FAIL tx_dropped_17th got frame %b expected none", bits); end
        checks++; if (tx_line !== 1'b1 || bus.Full !== 1'b0) begin errors++; $display("FAIL tx_idle_end got tx %b full %b expected 1 0", tx_line, bus.Full); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [9:0] bits;
        bit         found;
        int         n;
        bus.Enable_rx = 1'b1;
        push_tx(8'h00);
        n = 0;
        while (tx_line !== 1'b0 && n < 20 * BIT) begin @(negedge clk); n++; end
        b = 8'($urandom);
        rx_line = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 3; i++) begin rx_line = b[i]; wait_cycles(BIT); end
        checks++; if (tx_line !== 1'b0) begin errors++; $display("FAIL mid_tx_busy got %b expected 0", tx_line); end
        rst = 1'b1;
        #1;
        checks++; if (tx_line !== 1'b1) begin errors++; $display("FAIL mid_reset_tx got %b expected 1", tx_line); end
        checks++; if (bus.Empty !== 1'b1 || bus.Full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got empty %b full %b expected 1 0", bus.Empty, bus.Full); end
        rx_line = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3 * BIT);
        checks++; if (bus.Empty !== 1'b1 || tx_line !== 1'b1) begin errors++; $display("FAIL post_reset_idle got empty %b tx %b expected 1 1", bus.Empty, tx_line); end
        b = 8'($urandom);
        send_frame(b, 1'b1);
        wait_cycles(2);
        checks++; if (bus.RX_data !== b || bus.Empty !== 1'b0) begin errors++; $display("FAIL post_reset_rx got %h empty %b expected %h", bus.RX_data, bus.Empty, b); end
        pop_one();
        $display("rx after reset byte %h", b);
        b = 8'($urandom);
        push_tx(b);
        recv_tx(bits, found);
        checks++; if (!found || bits[8:1] !== b || bits[9] !== 1'b1) begin errors++; $display("FAIL post_reset_tx got found %b frame %b expected %h", found, bits, b); end
        $display("tx after reset byte %h", bits[8:1]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired before test sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_uart_en = 1'b0;
        bus.Enable_rx  = 1'b0;
        bus.TX_data    = 8'h00;
        bus.wr_uart_en = 1'b0;
        test_reset();
        test_single_rx();
        test_random_rx();
        test_back_to_back();
        test_overrun();
        test_tx();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
